// File: rtl/seq_divider_if.sv
// Request/response bundle for the multi-cycle divider.
// Both channels transfer on a rising clk edge where valid && ready are high; a master
// keeps its payload stable while valid is high and ready is low.
interface seq_divider_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic                  div_valid;
  logic                  div_ready;
  logic [3:0]            div_op;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output div_valid, div_op, dividend, divisor, out_ready,
    input  div_ready, out_valid, result
  );

  modport slave (
    input  div_valid, div_op, dividend, divisor, out_ready,
    output div_ready, out_valid, result
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for div/divu/rem/remu and their 32-bit word forms.
// One quotient bit per CALC cycle; divide-by-zero, overflow and bad opcodes bypass CALC.
module seq_divider #(
  parameter int DATA_WIDTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  seq_divider_if.slave bus,
  output logic [1:0]   dbg_state
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  result_q, result_d;
  logic          is_rem_q, is_rem_d;
  logic          is_word_q, is_word_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;

  logic [3:0]   op;
  logic [W-1:0] a, b, a_abs, b_abs, a_op, special_res;
  logic [31:0]  a_abs32, b_abs32;
  logic         op_valid, op_rem, op_uns, op_word, a_neg, b_neg, b_zero, ovf, special;

  always_comb begin
    op       = bus.div_op;
    a        = bus.dividend;
    b        = bus.divisor;
    op_valid = (op >= 4'd5) && (op <= 4'd12);
    op_rem   = (op >= 4'd9);
    op_uns   = (op == 4'd6) || (op == 4'd8) || (op == 4'd10) || (op == 4'd12);
    op_word  = (op == 4'd7) || (op == 4'd8) || (op == 4'd11) || (op == 4'd12);
    a_neg    = !op_uns && (op_word ? a[31] : a[W-1]);
    b_neg    = !op_uns && (op_word ? b[31] : b[W-1]);
    a_abs    = a_neg ? -a : a;
    b_abs    = b_neg ? -b : b;
    a_abs32  = a_neg ? -a[31:0] : a[31:0];
    b_abs32  = b_neg ? -b[31:0] : b[31:0];
    b_zero   = op_word ? (b[31:0] == 32'd0) : (b == '0);
    ovf      = !op_uns && (op_word ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                                   : (a == {1'b1, {(W-1){1'b0}}} && b == '1));
    a_op     = op_word ? {{(W-32){a[31]}}, a[31:0]} : a;
    special  = !op_valid || b_zero || ovf;
    // Zero divisor outranks overflow; both are resolved at the operation's width.
    if (!op_valid)   special_res = '0;
    else if (b_zero) special_res = op_rem ? a_op : '1;
    else             special_res = op_rem ? '0 : a_op;
  end

  logic [W:0]   rem_sh, diff;
  logic [W-1:0] rem_nx, quo_nx, fin_val, fin_s, fin_res;
  logic         ge, last, fin_neg;

  always_comb begin
    rem_sh  = {rem_q, quo_q[W-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    // Partial remainder stays below the divisor, so a clear top bit means "fits".
    ge      = !diff[W];
    rem_nx  = ge ? diff[W-1:0] : rem_sh[W-1:0];
    quo_nx  = {quo_q[W-2:0], ge};
    last    = (cnt_q == (is_word_q ? CW'(31) : CW'(W - 1)));
    fin_val = is_rem_q ? rem_nx : quo_nx;
    fin_neg = is_rem_q ? neg_rem_q : neg_quo_q;
    fin_s   = fin_neg ? -fin_val : fin_val;
    fin_res = is_word_q ? {{(W-32){fin_s[31]}}, fin_s[31:0]} : fin_s;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    is_rem_d  = is_rem_q;
    is_word_d = is_word_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.div_valid) begin
          is_rem_d  = op_rem;
          is_word_d = op_word;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (special) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            // Word dividends sit in the top half so their MSB shifts out first.
            rem_d   = '0;
            quo_d   = op_word ? {a_abs32, {(W-32){1'b0}}} : a_abs;
            dvs_d   = op_word ? {{(W-32){1'b0}}, b_abs32} : b_abs;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
        CALC: begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            result_d = fin_res;
            state_d  = DONE;
          end
        end
        DONE: if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      is_rem_q  <= 1'b0;
      is_word_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      is_rem_q  <= is_rem_d;
      is_word_q <= is_word_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign bus.div_ready = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] dbg_state;

  seq_divider_if #(.DATA_WIDTH(64)) bus ();
  seq_divider #(.DATA_WIDTH(64)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus), .dbg_state(dbg_state));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: RISC-V M-extension semantics expressed with native SV arithmetic.
  function automatic logic [63:0] model_res(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32;
    longint      sa, sb;
    int          sa32, sb32;
    logic        ovf64, ovf32;
    a32 = a[31:0];  b32 = b[31:0];
    sa = a;  sb = b;  sa32 = a32;  sb32 = b32;
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
    ovf32 = (a32 == 32'h8000_0000) && (b32 == '1);
    case (op)
      4'd5:  if (b == 0) return '1; else if (ovf64) return a; else return 64'(sa / sb);
      4'd6:  if (b == 0) return '1; else return a / b;
      4'd7:  if (b32 == 0) return '1; else if (ovf32) return sext32(a32); else return sext32(32'(sa32 / sb32));
      4'd8:  if (b32 == 0) return '1; else return sext32(a32 / b32);
      4'd9:  if (b == 0) return a; else if (ovf64) return 0; else return 64'(sa % sb);
      4'd10: if (b == 0) return a; else return a % b;
      4'd11: if (b32 == 0) return sext32(a32); else if (ovf32) return 0; else return sext32(32'(sa32 % sb32));
      4'd12: if (b32 == 0) return sext32(a32); else return sext32(a32 % b32);
      default: return 64'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic word, uns, zero, ovf;
    if (op < 4'd5 || op > 4'd12) return 1;
    word = (op == 4'd7) || (op == 4'd8) || (op == 4'd11) || (op == 4'd12);
    uns  = (op == 4'd6) || (op == 4'd8) || (op == 4'd10) || (op == 4'd12);
    zero = word ? (b[31:0] == 0) : (b == 0);
    ovf  = !uns && (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                         : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (zero || ovf) return 1;
    return word ? 33 : 65;
  endfunction

  // Scoreboard: expected result and latency for the single op in flight.
  logic [63:0] exp_q[$];
  int          lat_q[$];
  int          neg_cnt = 0;
  int          acc_neg = 0;
  bit          seen_valid = 0;

  always @(negedge clk) begin
    neg_cnt++;
    if (rst || flush) begin
      exp_q.delete();
      lat_q.delete();
      seen_valid = 0;
    end else begin
      if (exp_q.size() == 0) begin
        check("idle_out_valid", {63'd0, bus.out_valid}, 64'd0);
      end else if (bus.out_valid) begin
        if (!seen_valid) begin
          check("latency", 64'(neg_cnt - acc_neg), 64'(lat_q[0]));
          seen_valid = 1;
        end
        check("result", bus.result, exp_q[0]);
        check("ready_in_done", {63'd0, bus.div_ready}, 64'd0);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
          seen_valid = 0;
        end
      end else begin
        check("ready_in_calc", {63'd0, bus.div_ready}, 64'd0);
      end
      if (bus.div_valid && bus.div_ready) begin
        exp_q.push_back(model_res(bus.div_op, bus.dividend, bus.divisor));
        lat_q.push_back(model_lat(bus.div_op, bus.dividend, bus.divisor));
        acc_neg = neg_cnt;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int stall, output logic [63:0] got);
    int n;
    got = '0;
    bus.div_op = op;  bus.dividend = a;  bus.divisor = b;  bus.div_valid = 1'b1;
    n = 0;
    while (!bus.div_ready && n < 300) begin step(); n++; end
    if (!bus.div_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      bus.div_valid = 1'b0;
      return;
    end
    step();
    bus.div_valid = 1'b0;
    bus.div_op    = 4'($urandom_range(0, 15));
    bus.dividend  = {$urandom, $urandom};
    bus.divisor   = {$urandom, $urandom};
    n = 0;
    while (!bus.out_valid && n < 200) begin step(); n++; end
    if (!bus.out_valid) begin
      check("result_timeout", 64'd0, 64'd1);
      return;
    end
    got = bus.result;
    repeat (stall) step();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h0000_0000_8000_0000;
      4:       return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  logic [63:0] got;

  initial begin
    bus.div_valid = 1'b0;  bus.div_op = 4'd0;  bus.dividend = '0;  bus.divisor = '0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_div_ready", {63'd0, bus.div_ready}, 64'd1);
    check("rst_result", bus.result, 64'd0);
    rst = 1'b0;
    step();

    check("model_div_neg", model_res(4'd5, -64'sd7, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("model_remuw_zero", model_res(4'd12, 64'h1_8000_0005, 64'd0), 64'hFFFF_FFFF_8000_0005);
    check("model_lat_64", 64'(model_lat(4'd6, 64'd100, 64'd7)), 64'd65);
    check("model_lat_w", 64'(model_lat(4'd8, 64'hFFFF_FFFF, 64'd1)), 64'd33);

    run_op(4'd6, 64'd100, 64'd7, 0, got);   check("divu_100_7", got, 64'd14);
    run_op(4'd10, 64'd100, 64'd7, 1, got);  check("remu_100_7", got, 64'd2);
    run_op(4'd5, -64'sd7, 64'd2, 0, got);   check("div_m7_2", got, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(4'd9, -64'sd7, 64'd2, 0, got);   check("rem_m7_2", got, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(4'd7, 64'h8000_0000, '1, 0, got);  check("divw_ovf", got, 64'hFFFF_FFFF_8000_0000);
    run_op(4'd11, 64'h8000_0000, '1, 0, got); check("remw_ovf", got, 64'd0);
    run_op(4'd5, 64'h8000_0000_0000_0000, '1, 0, got); check("div_ovf", got, 64'h8000_0000_0000_0000);
    run_op(4'd6, 64'd1234, 64'd0, 0, got);  check("divu_zero", got, '1);
    run_op(4'd12, 64'h1_8000_0005, 64'd0, 0, got); check("remuw_zero", got, 64'hFFFF_FFFF_8000_0005);
    run_op(4'd8, 64'hFFFF_FFFF, 64'd1, 10, got); check("divuw_stall", got, '1);
    run_op(4'd0, 64'd50, 64'd5, 0, got);    check("bad_op_0", got, 64'd0);
    run_op(4'd13, 64'd50, 64'd5, 0, got);   check("bad_op_13", got, 64'd0);

    // Flush in CALC cycle 20 drops the op entirely.
    bus.div_op = 4'd6;  bus.dividend = 64'd1000;  bus.divisor = 64'd3;  bus.div_valid = 1'b1;
    step();
    bus.div_valid = 1'b0;
    repeat (19) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_ready", {63'd0, bus.div_ready}, 64'd1);
    repeat (70) step();
    run_op(4'd6, 64'd9, 64'd3, 0, got);     check("divu_after_flush", got, 64'd3);

    // Reset while a result waits in DONE.
    bus.div_op = 4'd6;  bus.dividend = 64'd77;  bus.divisor = 64'd0;  bus.div_valid = 1'b1;
    step();
    bus.div_valid = 1'b0;
    check("pre_rst_valid", {63'd0, bus.out_valid}, 64'd1);
    rst = 1'b1;
    step();
    check("rst_done_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_done_result", bus.result, 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 250; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(5, 12));
      run_op(op, rand_operand(), rand_operand(), $urandom_range(0, 3), got);
    end
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
